drom_responder: RTL and testbench

- Memory-side responder for the instruction fetch interface. It is the other end of the fetch read port.
- Accepts `addr`/`rd` requests, range-decodes them against the DROM window, and reads a synchronous ROM array.
- Returns `drom_data`, `hit` and `did` after a configurable number of wait states.
- Drives `busy`, which top level routes into the fetch `hold` input to stall the front end during wait states.

---
 rtl/params_pkg.sv | 24 ++
 rtl/drom_array.sv | 46 ++++
 rtl/drom_responder.sv | 156 +++++++++++++++
 tb/tb_drom_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared fetch-side parameters and types.
//   ADDR_W / INSTR_W        : address and instruction bus widths
//   DID_NONE / DID_DROM     : device ids returned with every response slot
//   DEF_DROM_BASE/DEF_DROM_DEPTH : default DROM window placement
//   resp_state_t            : responder FSM states
package params_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    // Fetch compares returned ids against DID_DROM, so this is the only definition.
    localparam logic [2:0] DID_NONE = 3'd0;
    localparam logic [2:0] DID_DROM = 3'd1;

    localparam int DEF_DROM_BASE  = 0;
    localparam int DEF_DROM_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/drom_array.sv
// Synchronous single-read-port ROM. Kept as its own module so a vendor ROM
// macro can replace it without touching the responder.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears the read register
//   rd_en : load the read register this edge
//   zero  : with rd_en, load zero instead of the addressed word
//   idx   : word index into the array
//   q     : registered read data, holds between reads
// Contents come from INIT_IMAGE (word i at bits [i*WIDTH +: WIDTH]). INIT_FILE
// names a hex image for macro-based builds; this behavioural array does not
// load files, so a non-empty name is flagged at elaboration.
module drom_array #(
    parameter int    DEPTH      = 256,
    parameter int    WIDTH      = 32,
    parameter string INIT_FILE  = "",
    parameter logic [DEPTH*WIDTH-1:0] INIT_IMAGE = '0,
    localparam int   IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             zero,
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = INIT_IMAGE[i*WIDTH +: WIDTH];
    end

    if (INIT_FILE != "") begin : g_init_file_check
        $error("drom_array: file images are loaded by the ROM macro; use INIT_IMAGE here");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (rd_en) begin
            q <= zero ? '0 : rom[idx];
        end
    end

endmodule

// File: rtl/drom_responder.sv
// Memory-side responder for the instruction fetch read port. Range-decodes a
// request against the DROM window, waits WAIT_STATES cycles, then presents a
// one-cycle response slot.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   addr, rd   : request word address and read strobe
//   drom_data  : response data (valid while hit=1, holds in IDLE)
//   hit        : response for a mapped address this cycle
//   did        : DID_DROM on a hit, DID_NONE otherwise
//   busy       : request in flight; routed to the fetch hold input
//   err        : one-cycle pulse in the response slot for an unmapped request
//   dbg_state  : current FSM state
// Handshake: rd is the request valid; the responder is ready whenever it is
// not in WAIT (busy=0). A request transfers on an edge where rd=1 and the
// state is IDLE or RESP. Once accepted it cannot be withdrawn: rd and addr
// are ignored until the response slot.
module drom_responder
    import params_pkg::*;
#(
    parameter int    ADDR_W      = params_pkg::ADDR_W,
    parameter int    INSTR_W     = params_pkg::INSTR_W,
    parameter int    DROM_BASE   = DEF_DROM_BASE,
    parameter int    DROM_DEPTH  = DEF_DROM_DEPTH,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = "",
    parameter logic [DROM_DEPTH*INSTR_W-1:0] INIT_IMAGE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               rd,
    output logic [INSTR_W-1:0] drom_data,
    output logic               hit,
    output logic [2:0]         did,
    output logic               busy,
    output logic               err,
    output resp_state_t        dbg_state
);

    localparam int IDX_W = (DROM_DEPTH > 1) ? $clog2(DROM_DEPTH) : 1;
    // Window bounds at ADDR_W+1 bits so base+depth at the top of the address
    // space does not wrap into low addresses.
    localparam logic [ADDR_W:0]   BASE_X  = (ADDR_W+1)'(DROM_BASE);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DROM_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(DROM_BASE);
    localparam logic [3:0]        WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if (DROM_DEPTH < 1 || DROM_BASE < 0 ||
        (longint'(DROM_BASE) + longint'(DROM_DEPTH)) > (longint'(1) << ADDR_W) ||
        WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_param_check
        $error("drom_responder: DROM window or WAIT_STATES out of range");
    end

    resp_state_t       state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              in_range_q;

    logic              accept;
    logic              in_range_new;
    logic              load_resp;
    logic              resp_in_range;
    logic [ADDR_W-1:0] addr_sel;
    logic [IDX_W-1:0]  rom_idx;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] ax;
        ax = {1'b0, a};
        return (ax >= BASE_X) && ((ax - BASE_X) < DEPTH_X);
    endfunction

    // With no wait states the ROM read and the accept share one edge, so the
    // read is indexed straight from the request; otherwise it is indexed from
    // the latched address on the last WAIT edge.
    always_comb begin
        accept       = ((state == IDLE) || (state == RESP)) && rd;
        in_range_new = in_window(addr);
        if (WAIT_STATES == 0) begin
            load_resp     = accept;
            resp_in_range = in_range_new;
            addr_sel      = addr;
        end else begin
            load_resp     = (state == WAIT) && (wait_cnt == 4'd0);
            resp_in_range = in_range_q;
            addr_sel      = addr_q;
        end
        rom_idx = IDX_W'(addr_sel - BASE_A);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            addr_q     <= '0;
            in_range_q <= 1'b0;
            hit        <= 1'b0;
            did        <= DID_NONE;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            hit  <= 1'b0;
            err  <= 1'b0;
            did  <= DID_NONE;
            busy <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_q     <= addr;
                        in_range_q <= in_range_new;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WS_LOAD;
                            busy     <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        busy     <= 1'b1;
                    end else begin
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load_resp) begin
                hit <= resp_in_range;
                err <= !resp_in_range;
                did <= resp_in_range ? DID_DROM : DID_NONE;
            end
        end
    end

    // Out-of-range responses load zero so drom_data reads 0 in the err slot.
    drom_array #(
        .DEPTH      (DROM_DEPTH),
        .WIDTH      (INSTR_W),
        .INIT_FILE  (INIT_FILE),
        .INIT_IMAGE (INIT_IMAGE)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .rd_en (load_resp),
        .zero  (!resp_in_range),
        .idx   (rom_idx),
        .q     (drom_data)
    );

    assign dbg_state = state;

endmodule

// File: tb/tb_drom_responder.sv
// Bench for drom_responder. Four instances cover the parameter sets:
//   u0: WAIT_STATES=1, window 0..255
//   u1: WAIT_STATES=0, window 0..255
//   u2: WAIT_STATES=1, window 0x100..0x10F
//   u3: WAIT_STATES=3, window 0..255
// ROM word i holds 0x1000_0000 + i*0x0101, except word 5 = 0xDEADBEEF.
module tb_drom_responder;
    import params_pkg::*;

    localparam int NI = 4;

    function automatic logic [31:0] img_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    function automatic logic [256*32-1:0] mk_img();
        logic [256*32-1:0] v;
        v = '0;
        for (int i = 0; i < 256; i++) v[i*32 +: 32] = img_word(i);
        return v;
    endfunction

    localparam logic [256*32-1:0] IMG256 = mk_img();
    localparam logic [16*32-1:0]  IMG16  = IMG256[16*32-1:0];

    int ws_a    [NI] = '{1, 0, 1, 3};
    int base_a  [NI] = '{0, 0, 256, 0};
    int depth_a [NI] = '{256, 256, 16, 256};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [NI];
    logic        rd_v   [NI];
    logic [15:0] addr_v [NI];
    logic [31:0] data_v [NI];
    logic        hit_v  [NI];
    logic [2:0]  did_v  [NI];
    logic        busy_v [NI];
    logic        err_v  [NI];
    resp_state_t dbg_v  [NI];

    drom_responder #(.DROM_BASE(0), .DROM_DEPTH(256), .WAIT_STATES(1), .INIT_IMAGE(IMG256)) u0 (
        .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .rd(rd_v[0]), .drom_data(data_v[0]),
        .hit(hit_v[0]), .did(did_v[0]), .busy(busy_v[0]), .err(err_v[0]), .dbg_state(dbg_v[0]));
    drom_responder #(.DROM_BASE(0), .DROM_DEPTH(256), .WAIT_STATES(0), .INIT_IMAGE(IMG256)) u1 (
        .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .rd(rd_v[1]), .drom_data(data_v[1]),
        .hit(hit_v[1]), .did(did_v[1]), .busy(busy_v[1]), .err(err_v[1]), .dbg_state(dbg_v[1]));
    drom_responder #(.DROM_BASE(256), .DROM_DEPTH(16), .WAIT_STATES(1), .INIT_IMAGE(IMG16)) u2 (
        .clk(clk), .rst(rst_v[2]), .addr(addr_v[2]), .rd(rd_v[2]), .drom_data(data_v[2]),
        .hit(hit_v[2]), .did(did_v[2]), .busy(busy_v[2]), .err(err_v[2]), .dbg_state(dbg_v[2]));
    drom_responder #(.DROM_BASE(0), .DROM_DEPTH(256), .WAIT_STATES(3), .INIT_IMAGE(IMG256)) u3 (
        .clk(clk), .rst(rst_v[3]), .addr(addr_v[3]), .rd(rd_v[3]), .drom_data(data_v[3]),
        .hit(hit_v[3]), .did(did_v[3]), .busy(busy_v[3]), .err(err_v[3]), .dbg_state(dbg_v[3]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One outstanding request per instance, answered on edge accept+WAIT_STATES.
    int          cyc = 0;
    bit          live = 1'b0;
    bit          pend_v    [NI];
    int          pend_edge [NI];
    logic [15:0] pend_addr [NI];
    logic        m_hit  [NI];
    logic        m_err  [NI];
    logic        m_busy [NI];
    logic [2:0]  m_did  [NI];
    logic [31:0] m_data [NI];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst_v[k]) begin
                pend_v[k] = 1'b0;
                m_hit[k] = 1'b0; m_err[k] = 1'b0; m_busy[k] = 1'b0;
                m_did[k] = DID_NONE; m_data[k] = 32'h0;
            end else begin
                bit was_busy;
                bit mapped;
                was_busy = pend_v[k];
                m_hit[k] = 1'b0; m_err[k] = 1'b0; m_did[k] = DID_NONE;
                if (!was_busy && rd_v[k]) begin
                    pend_v[k]    = 1'b1;
                    pend_addr[k] = addr_v[k];
                    pend_edge[k] = cyc + ws_a[k];
                end
                if (pend_v[k] && pend_edge[k] == cyc) begin
                    mapped = (int'(pend_addr[k]) >= base_a[k]) &&
                             (int'(pend_addr[k]) < base_a[k] + depth_a[k]);
                    m_hit[k]  = mapped;
                    m_err[k]  = !mapped;
                    m_did[k]  = mapped ? DID_DROM : DID_NONE;
                    m_data[k] = mapped ? img_word(int'(pend_addr[k]) - base_a[k]) : 32'h0;
                    pend_v[k] = 1'b0;
                end
                m_busy[k] = pend_v[k];
            end
        end
        live = 1'b1;
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("u%0d.hit", k),  32'(hit_v[k]),  32'(m_hit[k]));
                check($sformatf("u%0d.err", k),  32'(err_v[k]),  32'(m_err[k]));
                check($sformatf("u%0d.busy", k), 32'(busy_v[k]), 32'(m_busy[k]));
                check($sformatf("u%0d.did", k),  32'(did_v[k]),  32'(m_did[k]));
                check($sformatf("u%0d.data", k), data_v[k],      m_data[k]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input logic [15:0] a, input string nm,
                       input logic exp_hit, input logic [31:0] exp_data);
        int n;
        rd_v[k] = 1'b1; addr_v[k] = a;
        tick();
        rd_v[k] = 1'b0;
        n = 0;
        while (!(hit_v[k] || err_v[k]) && n < 20) begin
            tick();
            n++;
        end
        check({nm, ".seen"}, 32'(hit_v[k] | err_v[k]), 32'd1);
        check({nm, ".hit"},  32'(hit_v[k]), 32'(exp_hit));
        check({nm, ".err"},  32'(err_v[k]), 32'(!exp_hit));
        check({nm, ".did"},  32'(did_v[k]), exp_hit ? 32'd1 : 32'd0);
        check({nm, ".data"}, data_v[k], exp_data);
        tick();
    endtask

    logic [31:0] exp_q[$];

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int busy_n;
        logic [31:0] e;
        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b1; rd_v[k] = 1'b0; addr_v[k] = 16'h0;
        end

        // Reset then idle
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                check("rst.hit",  32'(hit_v[k]),  32'd0);
                check("rst.busy", 32'(busy_v[k]), 32'd0);
                check("rst.err",  32'(err_v[k]),  32'd0);
                check("rst.did",  32'(did_v[k]),  32'd0);
                check("rst.data", data_v[k],      32'd0);
            end
        end
        for (int k = 0; k < NI; k++) rst_v[k] = 1'b0;
        tick();

        // Single read, WAIT_STATES=1
        rd_v[0] = 1'b1; addr_v[0] = 16'd5;
        tick();
        rd_v[0] = 1'b0;
        check("single.busy1", 32'(busy_v[0]), 32'd1);
        check("single.hit0",  32'(hit_v[0]),  32'd0);
        tick();
        check("single.hit",  32'(hit_v[0]),  32'd1);
        check("single.did",  32'(did_v[0]),  32'd1);
        check("single.data", data_v[0],      32'hDEADBEEF);
        check("single.busy", 32'(busy_v[0]), 32'd0);
        tick();
        check("single.after_hit",  32'(hit_v[0]),  32'd0);
        check("single.after_busy", 32'(busy_v[0]), 32'd0);
        check("single.hold_data",  data_v[0],      32'hDEADBEEF);

        // Back-to-back, WAIT_STATES=0
        exp_q.push_back(32'h1000_0000);
        exp_q.push_back(32'h1000_0101);
        exp_q.push_back(32'h1000_0202);
        exp_q.push_back(32'h1000_0303);
        rd_v[1] = 1'b1; addr_v[1] = 16'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = exp_q.pop_front();
            check($sformatf("b2b[%0d].hit", i),  32'(hit_v[1]),  32'd1);
            check($sformatf("b2b[%0d].busy", i), 32'(busy_v[1]), 32'd0);
            check($sformatf("b2b[%0d].data", i), data_v[1],      e);
            addr_v[1] = 16'(i + 1);
            if (i == 3) rd_v[1] = 1'b0;
        end
        tick();
        check("b2b.end_hit", 32'(hit_v[1]), 32'd0);

        // Unmapped access, window 0x100..0x10F
        req(2, 16'h0110, "unmap.past_end", 1'b0, 32'h0);
        req(2, 16'h010F, "unmap.last",     1'b1, 32'h1000_0F0F);
        req(2, 16'h00FF, "unmap.below",    1'b0, 32'h0);
        req(2, 16'h0100, "unmap.first",    1'b1, 32'h1000_0000);

        // In-flight immunity, WAIT_STATES=3
        rd_v[3] = 1'b1; addr_v[3] = 16'd7;
        tick();
        addr_v[3] = 16'd9;
        busy_n = 0; n = 0;
        while (!hit_v[3] && n < 20) begin
            if (busy_v[3]) busy_n++;
            tick();
            rd_v[3] = 1'b0;
            n++;
        end
        check("imm.busy_cycles", 32'(busy_n), 32'd3);
        check("imm.hit",  32'(hit_v[3]), 32'd1);
        check("imm.data", data_v[3],     32'h1000_0707);
        tick();
        check("imm.after_hit", 32'(hit_v[3]), 32'd0);

        // Reset mid-request, WAIT_STATES=3
        rd_v[3] = 1'b1; addr_v[3] = 16'd3;
        tick();
        rd_v[3] = 1'b0;
        tick();
        check("midrst.busy_before", 32'(busy_v[3]), 32'd1);
        rst_v[3] = 1'b1;
        tick();
        rst_v[3] = 1'b0;
        check("midrst.state", 32'(dbg_v[3]),  32'(IDLE));
        check("midrst.hit",   32'(hit_v[3]),  32'd0);
        check("midrst.busy",  32'(busy_v[3]), 32'd0);
        check("midrst.err",   32'(err_v[3]),  32'd0);
        check("midrst.did",   32'(did_v[3]),  32'd0);
        check("midrst.data",  data_v[3],      32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("midrst.no_hit", 32'(hit_v[3]), 32'd0);
            check("midrst.no_err", 32'(err_v[3]), 32'd0);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
